// File: rtl/msrh_pkg.sv
// Shared scheduler types for the msrh core: register descriptors, issue
// payloads, wakeup bus records and the CSU issue-queue entry state.
package msrh_pkg;

  localparam int RNID_W       = 6;
  localparam int TGT_BUS_SIZE = 2;

  typedef enum logic { GPR = 1'b0, FPR = 1'b1 } reg_t;

  typedef struct packed {
    logic              valid;
    reg_t              typ;
    logic [RNID_W-1:0] rnid;
    logic              ready;
  } rd_reg_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   inst;
    rd_reg_t [1:0] rd_regs;
  } issue_t;

  typedef struct packed {
    logic              valid;
    reg_t              rd_type;
    logic [RNID_W-1:0] rd_rnid;
  } early_wr_t;

  typedef enum logic [1:0] {
    CSU_IQ_FREE   = 2'b00,
    CSU_IQ_WAIT   = 2'b01,
    CSU_IQ_ISSUED = 2'b10
  } csu_iq_state_t;

  function automatic logic early_wr_hit(early_wr_t ew, reg_t typ, logic [RNID_W-1:0] rnid);
    return ew.valid & (ew.rd_type == typ) & (ew.rd_rnid == rnid);
  endfunction

endpackage

// File: rtl/msrh_csu_iq_entry.sv
// One CSU issue-queue slot: lifecycle state, held instruction and the
// per-source readiness tracking driven by the early wakeup bus.
module msrh_csu_iq_entry
  import msrh_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          load,
  input  logic          issue,
  input  logic          done,
  input  logic          flush,
  input  issue_t        disp,
  input  early_wr_t     early_wr [TGT_BUS_SIZE],
  output csu_iq_state_t state,
  output issue_t        entry,
  output logic          all_ready
);

  csu_iq_state_t state_r, state_nxt_s;
  issue_t        entry_r, entry_nxt_s;
  logic [1:0]    disp_hit_s, wake_hit_s;

  // Wakeup compare for the incoming sources and the held sources; the physical
  // zero GPR is never a legal wakeup target for a held source.
  always_comb begin
    disp_hit_s = 2'b00;
    wake_hit_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < TGT_BUS_SIZE; k++) begin
        disp_hit_s[i] = disp_hit_s[i] |
                        early_wr_hit(early_wr[k], disp.rd_regs[i].typ, disp.rd_regs[i].rnid);
        wake_hit_s[i] = wake_hit_s[i] |
                        (early_wr_hit(early_wr[k], entry_r.rd_regs[i].typ, entry_r.rd_regs[i].rnid) &
                         !((entry_r.rd_regs[i].typ == GPR) && (entry_r.rd_regs[i].rnid == RNID_W'(0))));
      end
    end
  end

  // Entry lifecycle: flush dominates every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = CSU_IQ_FREE;
    end else begin
      case (state_r)
        CSU_IQ_FREE:   if (load)  state_nxt_s = CSU_IQ_WAIT;   else state_nxt_s = CSU_IQ_FREE;
        CSU_IQ_WAIT:   if (issue) state_nxt_s = CSU_IQ_ISSUED; else state_nxt_s = CSU_IQ_WAIT;
        CSU_IQ_ISSUED: if (done)  state_nxt_s = CSU_IQ_FREE;   else state_nxt_s = CSU_IQ_ISSUED;
        default:       state_nxt_s = CSU_IQ_FREE;
      endcase
    end
  end

  // Payload capture on load, then accumulate source wakeups while waiting.
  always_comb begin
    entry_nxt_s = entry_r;
    if (load && (state_r == CSU_IQ_FREE)) begin
      entry_nxt_s       = disp;
      entry_nxt_s.valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        entry_nxt_s.rd_regs[i].ready = !disp.rd_regs[i].valid | disp.rd_regs[i].ready | disp_hit_s[i];
      end
    end else if (state_r == CSU_IQ_WAIT) begin
      for (int i = 0; i < 2; i++) begin
        entry_nxt_s.rd_regs[i].ready = entry_r.rd_regs[i].ready | wake_hit_s[i];
      end
    end else begin
      entry_nxt_s = entry_r;
    end
  end

  // Entry state and payload registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= CSU_IQ_FREE;
      entry_r <= issue_t'({$bits(issue_t){1'b0}});
    end else begin
      state_r <= state_nxt_s;
      entry_r <= entry_nxt_s;
    end
  end

  assign state     = state_r;
  assign entry     = entry_r;
  assign all_ready = (state_r == CSU_IQ_WAIT) & entry_r.rd_regs[0].ready & entry_r.rd_regs[1].ready;

endmodule

// File: rtl/msrh_csu_issue_queue.sv
// In-order CSU issue queue: circular buffer of entries, head-only issue with
// at most one instruction in flight, retire on EX3 done, global flush.
module msrh_csu_issue_queue
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_disp_valid,
  input  issue_t                i_disp,
  output logic                  o_disp_ready,
  input  early_wr_t             i_early_wr [TGT_BUS_SIZE],
  output issue_t                o_issue,
  output logic [ENTRY_SIZE-1:0] o_issue_index,
  input  logic                  i_done_valid,
  input  logic [ENTRY_SIZE-1:0] i_done_index_oh,
  input  logic                  i_flush_valid,
  output logic                  o_empty
);

  localparam int IDX_W = $clog2(ENTRY_SIZE);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [IDX_W-1:0]      head_idx_s, tail_idx_s;
  logic [ENTRY_SIZE-1:0] head_oh_s, tail_oh_s;
  logic [ENTRY_SIZE-1:0] load_s, issue_s, done_s, all_ready_s, issued_s;
  logic                  empty_s, full_s, accept_s, issue_fire_s, done_fire_s;
  csu_iq_state_t         state_s [ENTRY_SIZE];
  issue_t                entry_s [ENTRY_SIZE];

  assign head_idx_s = head_r[IDX_W-1:0];
  assign tail_idx_s = tail_r[IDX_W-1:0];
  assign head_oh_s  = ENTRY_SIZE'(1'b1) << head_idx_s;
  assign tail_oh_s  = ENTRY_SIZE'(1'b1) << tail_idx_s;
  assign empty_s    = (head_r == tail_r);
  assign full_s     = (head_idx_s == tail_idx_s) & (head_r[IDX_W] != tail_r[IDX_W]);

  for (genvar g = 0; g < ENTRY_SIZE; g++) begin : g_entry
    msrh_csu_iq_entry u_entry (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .load      (load_s[g]),
      .issue     (issue_s[g]),
      .done      (done_s[g]),
      .flush     (i_flush_valid),
      .disp      (i_disp),
      .early_wr  (i_early_wr),
      .state     (state_s[g]),
      .entry     (entry_s[g]),
      .all_ready (all_ready_s[g])
    );
    assign issued_s[g] = (state_s[g] == CSU_IQ_ISSUED);
  end

  // Head-only issue select, done decode and pointer advance; flush wins.
  always_comb begin
    accept_s     = i_disp_valid & ~full_s & ~i_flush_valid;
    issue_fire_s = ~i_flush_valid & (state_s[head_idx_s] == CSU_IQ_WAIT) &
                   all_ready_s[head_idx_s] & ~|issued_s;
    done_fire_s  = ~i_flush_valid & i_done_valid & (i_done_index_oh == head_oh_s) &
                   (state_s[head_idx_s] == CSU_IQ_ISSUED);
    load_s  = accept_s     ? tail_oh_s : {ENTRY_SIZE{1'b0}};
    issue_s = issue_fire_s ? head_oh_s : {ENTRY_SIZE{1'b0}};
    done_s  = done_fire_s  ? head_oh_s : {ENTRY_SIZE{1'b0}};
    if (issue_fire_s) begin
      o_issue       = entry_s[head_idx_s];
      o_issue_index = head_oh_s;
    end else begin
      o_issue       = issue_t'({$bits(issue_t){1'b0}});
      o_issue_index = {ENTRY_SIZE{1'b0}};
    end
    if (i_flush_valid) begin
      head_nxt_s = {PTR_W{1'b0}};
      tail_nxt_s = {PTR_W{1'b0}};
    end else begin
      head_nxt_s = head_r + PTR_W'(done_fire_s);
      tail_nxt_s = tail_r + PTR_W'(accept_s);
    end
  end

  // Head/tail pointers, wrap bit in the MSB.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
    end
  end

  assign o_disp_ready = ~full_s;
  assign o_empty      = empty_s;

endmodule

// File: tb/tb_msrh_csu_issue_queue.sv
// Randomised + directed bench for msrh_csu_issue_queue: a queue-level model
// predicts per-cycle status and issue order; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_msrh_csu_issue_queue;
  import msrh_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic disp_valid, disp_ready, done_valid, flush, empty;
  issue_t disp, issue;
  logic [N-1:0] issue_index, done_oh;
  early_wr_t early_wr [TGT_BUS_SIZE];

  always #5 clk = ~clk;

  msrh_csu_issue_queue #(.ENTRY_SIZE(N)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_disp_valid(disp_valid), .i_disp(disp), .o_disp_ready(disp_ready),
    .i_early_wr(early_wr),
    .o_issue(issue), .o_issue_index(issue_index),
    .i_done_valid(done_valid), .i_done_index_oh(done_oh),
    .i_flush_valid(flush), .o_empty(empty)
  );

  typedef struct { issue_t ins; int slot; bit [1:0] rdy; bit issued; } m_ent_t;
  typedef struct { bit emp; bit rdy; bit vld; logic [N-1:0] idx; } st_t;
  typedef struct { logic [31:0] inst; logic [N-1:0] idx; } ie_t;
  typedef struct { int cyc; logic [N-1:0] oh; } pend_t;

  m_ent_t mq[$];
  st_t    st_q[$];
  ie_t    iss_q[$];
  pend_t  pend[$];
  logic [N-1:0] rec_idx[$];
  int     rec_cyc[$];
  int     tail_pos = 0, cyc = 0, n_chk = 0, n_fail = 0;
  bit     mon_en = 0, rec_en = 0, accepted = 0;

  bit        d_dv = 0, d_fl = 0, d_rst = 0, d_bogus = 0;
  issue_t    d_disp;
  early_wr_t d_ew [TGT_BUS_SIZE];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit ew_any(reg_t t, logic [RNID_W-1:0] r, bit no_gpr0);
    bit hit = 0;
    for (int k = 0; k < TGT_BUS_SIZE; k++)
      if (d_ew[k].valid && d_ew[k].rd_type == t && d_ew[k].rd_rnid == r) hit = 1;
    if (no_gpr0 && t == GPR && r == 0) hit = 0;
    return hit;
  endfunction

  function automatic issue_t mk(logic [31:0] inst, bit v, reg_t t, int rn, bit rdy);
    issue_t d;
    d = issue_t'(0);
    d.valid = 1'b1;
    d.inst = inst;
    d.rd_regs[0].valid = v;
    d.rd_regs[0].typ = t;
    d.rd_regs[0].rnid = RNID_W'(rn);
    d.rd_regs[0].ready = rdy;
    return d;
  endfunction

  function automatic issue_t rand_issue();
    issue_t d;
    d = issue_t'(0);
    d.valid = 1'b1;
    d.inst = $urandom();
    for (int s = 0; s < 2; s++) begin
      d.rd_regs[s].valid = 1'($urandom_range(1));
      d.rd_regs[s].typ = reg_t'(1'($urandom_range(1)));
      d.rd_regs[s].rnid = RNID_W'($urandom_range(7, 1));
      d.rd_regs[s].ready = ($urandom_range(2) == 0);
    end
    return d;
  endfunction

  // One clock: drive inputs after the edge, predict this cycle, update the model.
  task automatic step();
    int n;
    bit hit_issue, hit_done;
    logic dv_now;
    logic [N-1:0] oh_now, oh_head;
    m_ent_t e;
    st_t st;
    ie_t ie;
    pend_t p;
    @(posedge clk);
    #1;
    cyc++;
    dv_now = 1'b0;
    oh_now = '0;
    while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].cyc == cyc) begin
      dv_now = 1'b1;
      oh_now = pend[0].oh;
    end
    if (!dv_now && d_bogus) begin
      dv_now = 1'b1;
      oh_now[$urandom_range(N-1)] = 1'b1;
    end
    rst_n = !d_rst;
    disp_valid = d_dv;
    disp = d_disp;
    flush = d_fl;
    early_wr = d_ew;
    done_valid = dv_now;
    done_oh = oh_now;
    #2;
    n = mq.size();
    accepted = 0;
    if (d_rst) begin
      mq.delete();
      pend.delete();
      tail_pos = 0;
      st.emp = 1; st.rdy = 1; st.vld = 0; st.idx = '0;
      st_q.push_back(st);
    end else begin
      oh_head = '0;
      if (n > 0) oh_head[mq[0].slot] = 1'b1;
      hit_issue = !d_fl && n > 0 && !mq[0].issued && mq[0].rdy == 2'b11;
      hit_done  = !d_fl && n > 0 && mq[0].issued && dv_now && oh_now == oh_head;
      st.emp = (n == 0); st.rdy = (n < N); st.vld = hit_issue; st.idx = hit_issue ? oh_head : '0;
      st_q.push_back(st);
      if (hit_issue) begin
        ie.inst = mq[0].ins.inst; ie.idx = oh_head;
        iss_q.push_back(ie);
        p.cyc = cyc + 3; p.oh = oh_head;
        pend.push_back(p);
      end
      if (d_fl) begin
        mq.delete();
        tail_pos = 0;
      end else begin
        for (int i = 0; i < n; i++) begin
          e = mq[i];
          for (int s = 0; s < 2; s++)
            if (!e.issued && ew_any(e.ins.rd_regs[s].typ, e.ins.rd_regs[s].rnid, 1)) e.rdy[s] = 1;
          if (i == 0 && hit_issue) e.issued = 1;
          mq[i] = e;
        end
        if (hit_done) void'(mq.pop_front());
        if (d_dv && n < N) begin
          accepted = 1;
          e.ins = d_disp; e.slot = tail_pos % N; e.issued = 0;
          for (int s = 0; s < 2; s++)
            e.rdy[s] = !d_disp.rd_regs[s].valid || d_disp.rd_regs[s].ready ||
                       ew_any(d_disp.rd_regs[s].typ, d_disp.rd_regs[s].rnid, 0);
          mq.push_back(e);
          tail_pos++;
        end
      end
    end
    if (rec_en && issue.valid) begin
      rec_idx.push_back(issue_index);
      rec_cyc.push_back(cyc);
    end
    mon_en = 1;
    d_dv = 0; d_fl = 0; d_rst = 0; d_bogus = 0;
    for (int k = 0; k < TGT_BUS_SIZE; k++) d_ew[k] = early_wr_t'(0);
  endtask

  task automatic idle(int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic send(issue_t d);
    d_dv = 1; d_disp = d;
    step();
  endtask

  task automatic send_hold(issue_t d);
    for (int i = 0; i < 20; i++) begin
      d_dv = 1; d_disp = d;
      step();
      if (accepted) break;
    end
    if (!accepted) begin
      n_chk++; n_fail++;
      $display("FAIL hold_timeout: got not-accepted expected accepted");
    end
  endtask

  // Monitor: per-cycle status and in-order issue scoreboard.
  always @(negedge clk) begin
    st_t s;
    ie_t x;
    if (mon_en) begin
      if (st_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL status_underflow: got none expected entry");
      end else begin
        s = st_q.pop_front();
        chk("empty", empty, s.emp);
        chk("disp_ready", disp_ready, s.rdy);
        chk("issue_valid", issue.valid, s.vld);
        chk("issue_index", issue_index, s.idx);
      end
      if (issue.valid) begin
        if (iss_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL issue_unexpected: got inst %0h expected no issue", issue.inst);
        end else begin
          x = iss_q.pop_front();
          chk("issue_inst", issue.inst, x.inst);
          chk("issue_oh", issue_index, x.idx);
        end
      end
    end
  end

  initial begin
    d_disp = issue_t'(0);
    for (int k = 0; k < TGT_BUS_SIZE; k++) begin
      d_ew[k] = early_wr_t'(0);
      early_wr[k] = early_wr_t'(0);
    end
    rst_n = 0; disp_valid = 0; disp = issue_t'(0); flush = 0; done_valid = 0; done_oh = '0;
    #12;
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_issue_valid", issue.valid, 0);
    chk("rst_issue_index", issue_index, 0);

    // Ready CSRRW: issue next cycle, done 3 later, empty after.
    send(mk(32'h3400_1073, 1, GPR, 3, 1));
    step();
    chk("t1_issue_valid", issue.valid, 1);
    chk("t1_issue_index", issue_index, 4'b0001);
    idle(3);
    step();
    chk("t1_empty", empty, 1);

    // Wakeup: FPR 5 must not wake a GPR 5 source; GPR 5 does.
    send(mk(32'h1111_0001, 1, GPR, 5, 0));
    idle(1);
    d_ew[0] = '{valid: 1'b1, rd_type: FPR, rd_rnid: 6'd5};
    step();
    d_ew[1] = '{valid: 1'b1, rd_type: GPR, rd_rnid: 6'd5};
    step();
    chk("t2_no_early_issue", issue.valid, 0);
    step();
    chk("t2_wake_issue", issue.valid, 1);
    idle(6);

    // Fill, full back-pressure, 4-cycle spacing, wrap-around.
    d_fl = 1;
    step();
    rec_en = 1;
    for (int i = 0; i < 4; i++) send(mk(32'h2000_0000 + i, 0, GPR, 1, 0));
    d_dv = 1; d_disp = mk(32'h2000_0004, 0, GPR, 1, 0);
    step();
    chk("t3_full_ready", disp_ready, 0);
    send_hold(mk(32'h2000_0004, 0, GPR, 1, 0));
    send_hold(mk(32'h2000_0005, 0, GPR, 1, 0));
    idle(24);
    rec_en = 0;
    chk("t3_issue_count", rec_idx.size(), 6);
    if (rec_idx.size() == 6) begin
      chk("t3_idx0", rec_idx[0], 4'b0001);
      chk("t3_idx1", rec_idx[1], 4'b0010);
      chk("t3_idx2", rec_idx[2], 4'b0100);
      chk("t3_idx3", rec_idx[3], 4'b1000);
      chk("t3_idx4", rec_idx[4], 4'b0001);
      chk("t3_idx5", rec_idx[5], 4'b0010);
      for (int i = 1; i < 6; i++) chk("t3_spacing", rec_cyc[i] - rec_cyc[i-1], 4);
    end

    // Flush with head ISSUED and two waiting; stale done follows.
    send(mk(32'h3000_0000, 1, GPR, 3, 0));
    send(mk(32'h3000_0001, 1, GPR, 7, 0));
    d_ew[0] = '{valid: 1'b1, rd_type: GPR, rd_rnid: 6'd3};
    send(mk(32'h3000_0002, 1, GPR, 7, 0));
    step();
    chk("t4_head_issued", issue.valid, 1);
    d_fl = 1;
    step();
    step();
    chk("t4_flush_empty", empty, 1);
    step();
    chk("t4_stale_done_empty", empty, 1);
    send(mk(32'h3000_0003, 0, GPR, 1, 0));
    step();
    chk("t4_new_issue", issue.valid, 1);
    chk("t4_new_index", issue_index, 4'b0001);
    idle(5);

    // Same-cycle dispatch+wakeup, then same-cycle dispatch+flush.
    d_ew[1] = '{valid: 1'b1, rd_type: GPR, rd_rnid: 6'd9};
    send(mk(32'h4000_0000, 1, GPR, 9, 0));
    step();
    chk("t5_same_cycle_wake", issue.valid, 1);
    idle(5);
    d_fl = 1;
    send(mk(32'h4000_0001, 0, GPR, 1, 0));
    step();
    chk("t5_flush_drop_empty", empty, 1);

    // Random traffic with spurious dones, flushes and one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      d_dv = ($urandom_range(9) < 6);
      d_disp = rand_issue();
      d_fl = ($urandom_range(39) == 0);
      d_bogus = ($urandom_range(24) == 0);
      d_rst = (c == 700);
      for (int k = 0; k < TGT_BUS_SIZE; k++) begin
        d_ew[k].valid = 1'($urandom_range(1));
        d_ew[k].rd_type = reg_t'(1'($urandom_range(1)));
        d_ew[k].rd_rnid = RNID_W'($urandom_range(7));
      end
      step();
    end
    idle(30);
    #3;
    chk("status_drained", st_q.size(), 0);
    chk("issue_drained", iss_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
